decoder_nto2n_seq: RTL and testbench
====================================

// Module: decoder_nto2n_seq
// PURPOSE
//   Parametrised, registered N-to-2^N one-hot decoder. Successor to the gate-level 2-to-4 decoder.
//   DIRECT mode: decodes an accepted select code and holds the result.
//   SCAN mode: starts at the accepted code and steps the active output through all 2^N lines.
//   Each line is held for a programmable dwell time. Drives channel/row enables in larger designs.
// PARAMETERS
//   SEL_W   = 3  : select width; output count NOUT = 2**SEL_W
//   DWELL_W = 4  : width of dwell-count input
// PORTS
//   clk        in   1        clock, rising edge
//   rst_n      in   1        reset, asynchronous, active-low
//   en         in   1        global enable; low forces all outputs inactive
//   mode       in   1        0 = DIRECT, 1 = SCAN; sampled only on handshake
//   sel        in   SEL_W    select code / scan start index
//   sel_valid  in   1        sel/mode/dwell valid
//   sel_ready  out  1        block can accept a select
//   dwell      in   DWELL_W  extra hold cycles per line in SCAN; sampled on handshake
//   y          out  NOUT     one-hot decoded outputs, registered
//   busy       out  1        high while in SCAN state
//   wrap       out  1        1-cycle pulse when scan index wraps NOUT-1 -> 0
// BEHAVIOUR
//   - Reset (async, rst_n=0), all outputs and state:
//     y=0, busy=0, wrap=0, state=IDLE, idx=0, dcnt=0.
//     sel_ready follows its equation and reads 1 whenever en=1.
//   - sel_ready = en && (state != SCAN). Combinational from registered state.
//   - Handshake: accept = sel_valid && sel_ready. No acceptance while en=0 or during SCAN.
//   - States:
//     IDLE : y=0. On accept with mode=0, go to HOLD. On accept with mode=1, go to SCAN.
//     HOLD : y=onehot(latched sel). On accept, relatch; mode=1 on accept moves to SCAN.
//     SCAN : idx, dcnt counters; busy=1.
//   - Latency: accept at edge k -> y=onehot(sel) valid after edge k (1 cycle). Applies in both modes.
//   - SCAN stepping:
//     * On accept, idx=sel, dcnt=dwell.
//     * Each cycle: if dcnt!=0 then dcnt--. Else idx=idx+1 (mod NOUT) and dcnt=latched dwell.
//     * Each line is therefore held for dwell+1 cycles; dwell=0 steps every cycle.
//   - wrap: asserted in the same cycle that y first shows bit 0 after idx=NOUT-1.
//     A scan started at sel=0 does not pulse wrap at the start.
//   - SCAN runs until en=0. No other exit; mode/sel/dwell changes are ignored during SCAN.
//   - en=0 from any state: next edge y=0, busy=0, wrap=0, state=IDLE; latched data cleared.
//   - sel_valid while en=0 or in SCAN: ignored, never queued.
//   - Reset mid-scan: immediate async clear to reset values; no wrap pulse.
//   - y is always one-hot or all-zero; never more than one bit active.
// CONFIGURATION
//   DECSEQ_ACTIVE_LOW_EN
//     defined   : y is inverted at the output register.
//                 Inactive = all ones, reset value = all ones, active line = single 0.
//                 busy, wrap and sel_ready are unchanged.
//     undefined : y is active-high as above; reset value = all zeros.
// TESTING (SEL_W=3, DWELL_W=4, active-high unless noted)
//   1. Reset:
//      rst_n=0 asynchronously mid-cycle -> y=8'h00, busy=0, wrap=0 immediately.
//      Release with en=1 -> sel_ready=1.
//   2. DIRECT:
//      en=1, mode=0, sel=5, sel_valid for 1 cycle -> y=8'h20 after next edge, held 10 cycles.
//      Then sel=2 accepted -> y=8'h04.
//   3. SCAN with dwell:
//      mode=1, sel=6, dwell=1 -> y=8'h40 for 2 cycles, then 8'h80 for 2 cycles.
//      Then 8'h01 with wrap=1 for the first cycle only, then 8'h02.
//      busy=1 and sel_ready=0 throughout.
//   4. SCAN dwell=0 from sel=0:
//      y steps 01,02,04,...,80,01 one per cycle.
//      wrap pulses only at the 80->01 step. sel_valid with sel=3 during the scan is ignored.
//   5. en drop mid-scan:
//      en=0 while y=8'h08 -> next edge y=0, busy=0.
//      en=1 again -> sel_ready=1, state IDLE, y stays 0 until accept.
//   6. DECSEQ_ACTIVE_LOW_EN build:
//      Reset -> y=8'hFF. DIRECT sel=5 -> y=8'hDF. en=0 -> y=8'hFF.

Source files
------------

// File: rtl/decoder_nto2n_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : decoder_nto2n_seq
// Description : Registered N-to-2^N one-hot decoder with two modes.
//               DIRECT mode decodes an accepted select code and holds the
//               result. SCAN mode starts at the accepted code and walks the
//               active line through all 2^N outputs. Each line is held for
//               dwell+1 cycles. SCAN is left only when en_i drops.
//
// Configuration macro:
//   DECSEQ_ACTIVE_LOW_EN : when defined, y_o is inverted at the output
//                          register. Inactive is all ones and the active line
//                          is a single 0. busy_o, wrap_o and sel_ready_o are
//                          not affected.
//
// Ports:
//   clk          in   1        clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   en_i         in   1        global enable; low forces outputs inactive
//   mode_i       in   1        0 = DIRECT, 1 = SCAN (sampled on handshake)
//   sel_i        in   SEL_W    select code / scan start index
//   sel_valid_i  in   1        sel_i / mode_i / dwell_i valid
//   sel_ready_o  out  1        block can accept a select
//   dwell_i      in   DWELL_W  extra hold cycles per line in SCAN
//   y_o          out  NOUT     one-hot decoded outputs, registered
//   busy_o       out  1        high while scanning
//   wrap_o       out  1        1-cycle pulse when scan wraps NOUT-1 -> 0
//
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

module decoder_nto2n_seq #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  mode_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic                  sel_valid_i,
    output logic                  sel_ready_o,
    input  logic [DWELL_W-1:0]    dwell_i,
    output logic [(2**SEL_W)-1:0] y_o,
    output logic                  busy_o,
    output logic                  wrap_o
);

    localparam int NOUT = 2**SEL_W;

    // Pattern that y_o shows when no line is active. Every active line is
    // produced by XOR-ing a single one-hot bit into this pattern, so the
    // output polarity is decided here and nowhere else.
`ifdef DECSEQ_ACTIVE_LOW_EN
    localparam logic [NOUT-1:0] c_Y_INACTIVE = {NOUT{1'b1}};
`else
    localparam logic [NOUT-1:0] c_Y_INACTIVE = {NOUT{1'b0}};
`endif

    localparam logic [NOUT-1:0]    c_ONE_HOT0 = NOUT'(1);
    localparam logic [SEL_W-1:0]   c_IDX_LAST = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0]   c_IDX_ONE  = SEL_W'(1);
    localparam logic [DWELL_W-1:0] c_DCNT_ONE = DWELL_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     idx_q,   idx_d;
    logic [DWELL_W-1:0]   dcnt_q,  dcnt_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [NOUT-1:0]      y_q,     y_d;
    logic                 wrap_q,  wrap_d;

    logic                 w_accept;
    logic [SEL_W-1:0]     w_idx_next;

    // Output pattern for a single active line at index i_idx.
    function automatic logic [NOUT-1:0] f_line(input logic [SEL_W-1:0] i_idx);
        f_line = c_Y_INACTIVE ^ (c_ONE_HOT0 << i_idx);
    endfunction

    // Ready depends on registered state only, so no combinational path from
    // sel_valid_i back to sel_ready_o.
    assign sel_ready_o = en_i && (state_q != ST_SCAN);
    assign w_accept    = sel_valid_i && sel_ready_o;

    // Natural truncation to SEL_W bits gives the modulo-NOUT wrap.
    assign w_idx_next  = idx_q + c_IDX_ONE;

    //--------------------------------------------------------------------------
    // Next-state / datapath logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dcnt_d  = dcnt_q;
        dwell_d = dwell_q;
        y_d     = y_q;
        wrap_d  = 1'b0;

        if (!en_i) begin
            // Disable wins over everything and wipes the latched request.
            state_d = ST_IDLE;
            idx_d   = '0;
            dcnt_d  = '0;
            dwell_d = '0;
            y_d     = c_Y_INACTIVE;
        end else begin
            case (state_q)
                ST_IDLE,
                ST_HOLD: begin
                    if (w_accept) begin
                        idx_d   = sel_i;
                        dcnt_d  = dwell_i;
                        dwell_d = dwell_i;
                        y_d     = f_line(sel_i);
                        state_d = mode_i ? ST_SCAN : ST_HOLD;
                    end else if (state_q == ST_IDLE) begin
                        y_d = c_Y_INACTIVE;
                    end
                end

                ST_SCAN: begin
                    if (dcnt_q != '0) begin
                        dcnt_d = dcnt_q - c_DCNT_ONE;
                    end else begin
                        // Dwell exhausted: move to the next line and reload.
                        idx_d  = w_idx_next;
                        dcnt_d = dwell_q;
                        y_d    = f_line(w_idx_next);
                        // Only a real step from the last line wraps; the
                        // start of a scan at index 0 goes through the accept
                        // path and never raises wrap.
                        wrap_d = (idx_q == c_IDX_LAST);
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    dcnt_d  = '0;
                    dwell_d = '0;
                    y_d     = c_Y_INACTIVE;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dcnt_q  <= '0;
            dwell_q <= '0;
            y_q     <= c_Y_INACTIVE;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dcnt_q  <= dcnt_d;
            dwell_q <= dwell_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign y_o    = y_q;
    assign busy_o = (state_q == ST_SCAN);
    assign wrap_o = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_decoder_nto2n_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_decoder_nto2n_seq
// Description : Self-checking bench for decoder_nto2n_seq (SEL_W=3,
//               DWELL_W=4). A behavioural model predicts the outputs: in a
//               scan, the active line is derived arithmetically from the
//               number of cycles elapsed since the scan was accepted.
//               Honors DECSEQ_ACTIVE_LOW_EN for the expected y polarity.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

module tb_decoder_nto2n_seq;

    localparam int SEL_W   = 3;
    localparam int DWELL_W = 4;
    localparam int NOUT    = 8;

    logic               clk         = 1'b0;
    logic               rst_n       = 1'b0;
    logic               en_i        = 1'b0;
    logic               mode_i      = 1'b0;
    logic [SEL_W-1:0]   sel_i       = '0;
    logic               sel_valid_i = 1'b0;
    logic [DWELL_W-1:0] dwell_i     = '0;
    logic               sel_ready_o;
    logic [NOUT-1:0]    y_o;
    logic               busy_o;
    logic               wrap_o;

    int n_cmp = 0;
    int n_mis = 0;

    // Model: 0 = idle, 1 = holding a decoded code, 2 = scanning.
    int m_state = 0;
    int m_sel   = 0;
    int m_dwell = 0;
    int m_t     = 0;   // cycles elapsed since the scan was accepted

    decoder_nto2n_seq #(
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en_i),
        .mode_i      (mode_i),
        .sel_i       (sel_i),
        .sel_valid_i (sel_valid_i),
        .sel_ready_o (sel_ready_o),
        .dwell_i     (dwell_i),
        .y_o         (y_o),
        .busy_o      (busy_o),
        .wrap_o      (wrap_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NOUT-1:0] polar(input logic [NOUT-1:0] v);
`ifdef DECSEQ_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    function automatic int m_line();
        return (m_sel + m_t / (m_dwell + 1)) % NOUT;
    endfunction

    function automatic logic [NOUT-1:0] m_y();
        logic [NOUT-1:0] one;
        one = 8'h01;
        if (m_state == 0) return polar(8'h00);
        if (m_state == 1) return polar(one << m_sel);
        return polar(one << m_line());
    endfunction

    function automatic logic m_wrap();
        return (m_state == 2) && (m_t > 0) && (m_t % (m_dwell + 1) == 0) && (m_line() == 0);
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_sel   = 0;
        m_dwell = 0;
        m_t     = 0;
    endtask

    task automatic check_outputs();
        check("y",         y_o,         m_y());
        check("busy",      busy_o,      m_state == 2);
        check("wrap",      wrap_o,      m_wrap());
        check("sel_ready", sel_ready_o, en_i && (m_state != 2));
    endtask

    // Advance the model with the inputs currently applied, clock once, check.
    task automatic cycle();
        bit rdy;
        rdy = en_i && (m_state != 2);
        if (!en_i) begin
            model_reset();
        end else if (sel_valid_i && rdy) begin
            m_state = mode_i ? 2 : 1;
            m_sel   = sel_i;
            m_dwell = dwell_i;
            m_t     = 0;
        end else if (m_state == 2) begin
            m_t++;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_y",    y_o,    polar(8'h00));
        check("rst_busy", busy_o, 1'b0);
        check("rst_wrap", wrap_o, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", sel_ready_o, en_i);
    endtask

    task automatic request(input logic m, input int s, input int d);
        mode_i      = m;
        sel_i       = SEL_W'(s);
        dwell_i     = DWELL_W'(d);
        sel_valid_i = 1'b1;
        cycle();
        sel_valid_i = 1'b0;
    endtask

    initial begin
        en_i = 1'b1;
        do_reset();

        // DIRECT decode, held, then relatched.
        request(1'b0, 5, 0);
        check("direct5", y_o, polar(8'h20));
        repeat (10) cycle();
        request(1'b0, 2, 0);
        check("direct2", y_o, polar(8'h04));
        cycle();

        // SCAN from 6 with dwell 1, through the wrap.
        request(1'b1, 6, 1);
        repeat (9) cycle();

        // Drop enable mid-scan, then re-enable and stay idle.
        en_i = 1'b0;
        cycle();
        en_i = 1'b1;
        repeat (3) cycle();

        // SCAN from 0 with dwell 0; a new request during the scan is ignored.
        request(1'b1, 0, 0);
        repeat (2) cycle();
        request(1'b0, 3, 5);
        repeat (12) cycle();
        en_i = 1'b0;
        cycle();
        en_i = 1'b1;
        cycle();

        // Reset in the middle of a scan.
        request(1'b1, 7, 2);
        repeat (4) cycle();
        do_reset();
        cycle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            en_i        = ($urandom_range(0, 39) != 0);
            sel_valid_i = ($urandom_range(0, 2) == 0);
            mode_i      = $urandom_range(0, 1);
            sel_i       = SEL_W'($urandom_range(0, NOUT - 1));
            dwell_i     = ($urandom_range(0, 3) == 0) ? DWELL_W'($urandom_range(0, 15))
                                                      : DWELL_W'($urandom_range(0, 2));
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
